// File: rtl/uart_word_tx_pkg.sv
// Shared definitions for the word-level UART transmitter: parity modes,
// FSM state encoding and the serial line idle level.
package uart_word_tx_pkg;

    // Parity modes selected by the PARITY parameter
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Level of the serial line when nothing is being sent (also the stop level)
    localparam logic LINE_IDLE = 1'b1;

    // Transmitter FSM states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

endpackage

// File: rtl/uart_word_tx_baud_gen.sv
// Bit-period divider: counts 0..CLK_DIV-1 and flags the last cycle of each
// bit period. A clear restarts the period so a new start bit is full length.
module uart_word_tx_baud_gen #(
    parameter int CLK_DIV = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Divider counter: restart on clear, reload to zero after the last cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_tick = (cnt == LAST);

endmodule

// File: rtl/uart_word_tx.sv
// Word-level UART transmitter: accepts one NUM_BYTES*DATA_BITS word via a
// valid/ready handshake and sends it as back-to-back frames, byte 0 first,
// each byte LSB first, with optional parity and one or two stop bits.
//
// Handshake: a word is taken on a rising edge where tx_valid && tx_ready.
// tx_ready is high only in IDLE; tx_valid outside IDLE is ignored and
// tx_data is free to change once the word has been taken.
module uart_word_tx
    import uart_word_tx_pkg::*;
#(
    parameter int CLK_DIV   = 20,
    parameter int DATA_BITS = 8,
    parameter int NUM_BYTES = 4,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_BYTES*DATA_BITS-1:0] tx_data,
    input  logic                           tx_valid,
    output logic                           tx_ready,
    output logic                           tx_out,
    output logic                           busy,
    output logic                           done,
    output state_t                         fsm_state
);

    localparam int WORD_W = NUM_BYTES * DATA_BITS;
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam int BYTE_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);

    if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 || NUM_BYTES < 1 ||
        PARITY < PAR_NONE || PARITY > PAR_ODD || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
        $error("uart_word_tx: illegal parameter set");
    end

    state_t              state_q, state_d;
    logic [BIT_W-1:0]    bit_idx, bit_d, bit_nxt;
    logic [BYTE_W-1:0]   byte_idx, byte_d, byte_nxt;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [DATA_BITS-1:0] cur_byte;
    logic                line_q, line_d;
    logic                done_q, done_d;
    logic                par_bit;
    logic                baud_clear;
    logic                bit_tick;

    uart_word_tx_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (baud_clear),
        .bit_tick (bit_tick)
    );

    assign bit_nxt  = bit_idx + 1'b1;
    assign byte_nxt = byte_idx + 1'b1;

    // Select the byte currently being framed out of the captured word
    always_comb begin
        cur_byte = '0;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (byte_idx == BYTE_W'(k)) cur_byte = word_q[k*DATA_BITS +: DATA_BITS];
        end
    end

    assign par_bit = (PARITY == PAR_ODD) ? ~(^cur_byte) : ^cur_byte;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next state, index updates and next line level; every bit change lands on a tick
    always_comb begin
        state_d    = state_q;
        bit_d      = bit_idx;
        byte_d     = byte_idx;
        word_d     = word_q;
        line_d     = line_q;
        done_d     = 1'b0;
        baud_clear = 1'b0;
        case (state_q)
            S_IDLE: begin
                line_d = LINE_IDLE;
                if (tx_valid) begin
                    word_d     = tx_data;
                    byte_d     = '0;
                    bit_d      = '0;
                    line_d     = ~LINE_IDLE;
                    baud_clear = 1'b1;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (bit_tick) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    line_d  = cur_byte[0];
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    if (bit_idx == LAST_BIT) begin
                        bit_d = '0;
                        if (PARITY != PAR_NONE) begin
                            state_d = S_PAR;
                            line_d  = par_bit;
                        end else begin
                            state_d = S_STOP;
                            line_d  = LINE_IDLE;
                        end
                    end else begin
                        bit_d  = bit_nxt;
                        line_d = cur_byte[bit_nxt];
                    end
                end
            end
            S_PAR: begin
                if (bit_tick) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                    line_d  = LINE_IDLE;
                end
            end
            S_STOP: begin
                if (bit_tick) begin
                    if (bit_idx == LAST_STOP) begin
                        bit_d = '0;
                        if (byte_idx == LAST_BYTE) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            byte_d  = byte_nxt;
                            state_d = S_START;
                            line_d  = ~LINE_IDLE;
                        end
                    end else begin
                        bit_d = bit_nxt;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                line_d  = LINE_IDLE;
            end
        endcase
    end

    // Datapath registers: word, indices, registered line and done pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q   <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            line_q   <= LINE_IDLE;
            done_q   <= 1'b0;
        end else begin
            word_q   <= word_d;
            bit_idx  <= bit_d;
            byte_idx <= byte_d;
            line_q   <= line_d;
            done_q   <= done_d;
        end
    end

    assign tx_out    = line_q;
    assign done      = done_q;
    assign tx_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign fsm_state = state_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: four parameter sets side by side, a UART receive
// model that samples each bit mid-period, and an expected-byte queue.
module tb_uart_word_tx;
    import uart_word_tx_pkg::*;

    localparam int NU = 4;
    localparam int P_DIV [NU] = '{20, 4, 5, 2};
    localparam int P_DB  [NU] = '{8, 7, 7, 6};
    localparam int P_NB  [NU] = '{4, 2, 1, 3};
    localparam int P_PAR [NU] = '{0, 1, 2, 0};
    localparam int P_SB  [NU] = '{1, 2, 1, 2};

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [63:0]   data_v [NU];
    logic [NU-1:0] valid_v;
    logic [NU-1:0] ready_v, out_v, busy_v, done_v;
    state_t        st_v [NU];

    logic [7:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    uart_word_tx #(.CLK_DIV(20), .DATA_BITS(8), .NUM_BYTES(4), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .tx_data(data_v[0][31:0]), .tx_valid(valid_v[0]), .tx_ready(ready_v[0]),
        .tx_out(out_v[0]), .busy(busy_v[0]), .done(done_v[0]), .fsm_state(st_v[0]));
    uart_word_tx #(.CLK_DIV(4), .DATA_BITS(7), .NUM_BYTES(2), .PARITY(1), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst(rst), .tx_data(data_v[1][13:0]), .tx_valid(valid_v[1]), .tx_ready(ready_v[1]),
        .tx_out(out_v[1]), .busy(busy_v[1]), .done(done_v[1]), .fsm_state(st_v[1]));
    uart_word_tx #(.CLK_DIV(5), .DATA_BITS(7), .NUM_BYTES(1), .PARITY(2), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst(rst), .tx_data(data_v[2][6:0]), .tx_valid(valid_v[2]), .tx_ready(ready_v[2]),
        .tx_out(out_v[2]), .busy(busy_v[2]), .done(done_v[2]), .fsm_state(st_v[2]));
    uart_word_tx #(.CLK_DIV(2), .DATA_BITS(6), .NUM_BYTES(3), .PARITY(0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rst(rst), .tx_data(data_v[3][17:0]), .tx_valid(valid_v[3]), .tx_ready(ready_v[3]),
        .tx_out(out_v[3]), .busy(busy_v[3]), .done(done_v[3]), .fsm_state(st_v[3]));

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] lo_mask(input int n);
        return (64'd1 << n) - 64'd1;
    endfunction

    function automatic int word_width(input int u);
        return P_NB[u] * P_DB[u];
    endfunction

    // ---------------- driver tasks ----------------
    // Wait (bounded) for ready, present the word, and return just after the accepting edge
    task automatic accept(input int u, input logic [63:0] w);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready_v[u] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq($sformatf("ready_wait_u%0d", u), ready_v[u], 1'b1);
        data_v[u]  = w;
        valid_v[u] = 1'b1;
        @(posedge clk);
    endtask

    // Follow a word from its accepting edge to its done cycle, decoding the
    // line with a mid-bit sampling receiver. hold keeps tx_valid high with
    // the next word; noise wiggles tx_valid/tx_data while the block is busy.
    task automatic observe(input int u, input logic [63:0] w, input bit hold,
                           input logic [63:0] nxt, input bit noise);
        int d, db, nb, p, sb, f, total, bi, pos;
        logic [15:0] fb;
        logic [63:0] rx, exp_b;
        logic        exp_par;
        d  = P_DIV[u];
        db = P_DB[u];
        nb = P_NB[u];
        p  = P_PAR[u];
        sb = P_SB[u];
        f  = 1 + db + ((p != 0) ? 1 : 0) + sb;
        total = nb * f * d;
        fb = '0;
        for (int k = 0; k < nb; k++) exp_q.push_back(8'((w >> (k * db)) & lo_mask(db)));
        for (int c = 0; c <= total; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check_eq($sformatf("start_line_u%0d", u), out_v[u], 1'b0);
                check_eq($sformatf("start_ready_u%0d", u), ready_v[u], 1'b0);
                check_eq($sformatf("start_busy_u%0d", u), busy_v[u], 1'b1);
                check_eq($sformatf("start_done_u%0d", u), done_v[u], 1'b0);
            end else if (c == total - 1) begin
                check_eq($sformatf("last_stop_line_u%0d", u), out_v[u], 1'b1);
                check_eq($sformatf("early_done_u%0d", u), done_v[u], 1'b0);
            end else if (c == total) begin
                check_eq($sformatf("done_u%0d", u), done_v[u], 1'b1);
                check_eq($sformatf("done_busy_u%0d", u), busy_v[u], 1'b0);
                check_eq($sformatf("done_ready_u%0d", u), ready_v[u], 1'b1);
                check_eq($sformatf("done_line_u%0d", u), out_v[u], 1'b1);
            end
            if (c < total && (c % d) == d / 2) begin
                bi  = c / d;
                pos = bi % f;
                fb[pos] = out_v[u];
                if (pos == f - 1) begin
                    check_eq($sformatf("busy_u%0d", u), busy_v[u], 1'b1);
                    check_eq($sformatf("rx_start_u%0d", u), fb[0], 1'b0);
                    rx    = (64'(fb) >> 1) & lo_mask(db);
                    exp_b = (exp_q.size() > 0) ? 64'(exp_q.pop_front()) : 'x;
                    check_eq($sformatf("rx_byte_u%0d_f%0d", u, bi / f), rx, exp_b);
                    if (p != 0) begin
                        exp_par = (($countones(rx) % 2) == 1) ^ (p == 2);
                        check_eq($sformatf("rx_parity_u%0d", u), fb[db+1], exp_par);
                    end
                    check_eq($sformatf("rx_stop_u%0d", u),
                             (64'(fb) >> (1 + db + ((p != 0) ? 1 : 0))) & lo_mask(sb), lo_mask(sb));
                end
            end
            if (hold) begin
                data_v[u]  = nxt;
                valid_v[u] = 1'b1;
            end else if (noise && c < total) begin
                valid_v[u] = 1'($urandom_range(0, 1));
                data_v[u]  = {$urandom, $urandom};
            end else begin
                valid_v[u] = 1'b0;
            end
        end
        check_eq($sformatf("exp_left_u%0d", u), 64'(exp_q.size()), 0);
    endtask

    function automatic logic [63:0] rand_word(input int u);
        return {$urandom, $urandom} & lo_mask(word_width(u));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] w, w2;
        int u, r;
        for (int i = 0; i < NU; i++) data_v[i] = '0;
        valid_v = '0;

        // reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NU; i++) begin
            check_eq($sformatf("rst_line_u%0d", i), out_v[i], 1'b1);
            check_eq($sformatf("rst_ready_u%0d", i), ready_v[i], 1'b1);
            check_eq($sformatf("rst_busy_u%0d", i), busy_v[i], 1'b0);
            check_eq($sformatf("rst_done_u%0d", i), done_v[i], 1'b0);
            check_eq($sformatf("rst_state_u%0d", i), st_v[i], S_IDLE);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // defaults, fixed word: frames 01, 0F, 5A, A5 and done 800 cycles on
        accept(0, 64'hA55A_0F01);
        observe(0, 64'hA55A_0F01, 1'b0, '0, 1'b0);

        // even parity, 7 data bits, two stop bits; byte 0 = 0x55
        w = (64'h2A << 7) | 64'h55;
        accept(1, w);
        observe(1, w, 1'b0, '0, 1'b0);

        // odd parity, single 7-bit byte 0x55 -> parity bit 1
        accept(2, 64'h55);
        observe(2, 64'h55, 1'b0, '0, 1'b0);

        // tx_valid held through a word: next word taken in the done cycle
        w  = rand_word(1);
        w2 = rand_word(1);
        accept(1, w);
        observe(1, w, 1'b1, w2, 1'b0);
        @(posedge clk);
        observe(1, w2, 1'b0, '0, 1'b1);

        // reset in the middle of byte 2 on the default instance
        w = rand_word(0);
        accept(0, w);
        valid_v[0] = 1'b0;
        repeat (2 * 10 * 20 + 5 * 20) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("midrst_line", out_v[0], 1'b1);
        check_eq("midrst_busy", busy_v[0], 1'b0);
        check_eq("midrst_ready", ready_v[0], 1'b1);
        check_eq("midrst_done", done_v[0], 1'b0);
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            check_eq("inrst_done", done_v[0], 1'b0);
            check_eq("inrst_line", out_v[0], 1'b1);
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_eq("postrst_done", done_v[0], 1'b0);
            check_eq("postrst_line", out_v[0], 1'b1);
        end
        w = rand_word(0);
        accept(0, w);
        observe(0, w, 1'b0, '0, 1'b0);

        // 200 random words over random parameter sets, with handshake noise
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 7);
            u = (r == 0) ? 0 : 1 + (r % 3);
            w = rand_word(u);
            accept(u, w);
            observe(u, w, 1'b0, '0, 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
